// File: rtl/store_merge_unit.sv
// Read-modify-write engine for sub-word stores: fetch aligned word, merge lanes, write back.
// One request in flight; req_ready_o is low outside IDLE. Full-width stores skip the read.
module store_merge_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] aln_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] merge_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              re_q;
  logic              we_q;
  logic              done_q;
  logic              err_q;

  logic [OFF_W-1:0]  req_off;
  logic [OFF_W-1:0]  size_mask;
  logic              req_bad;
  logic              req_full;
  logic [DATA_W-1:0] bit_mask;

  assign req_off  = req_addr_i[OFF_W-1:0];
  assign req_bad  = (int'(req_size_i) > OFF_W) || ((req_off & size_mask) != '0);
  assign req_full = (int'(req_size_i) == OFF_W);

  always_comb begin
    size_mask = OFF_W'((1 << req_size_i) - 1);
  end

  // Lanes [off, off+2^size-1] take the shifted store bytes; the rest keep the fetched word.
  always_comb begin
    bit_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      if (l >= int'(off_q) && l < int'(off_q) + (1 << size_q)) begin
        bit_mask[l*8 +: 8] = 8'hFF;
      end
    end
    merge_d = (mem_rdata_i & ~bit_mask) | ((data_q << {off_q, 3'b000}) & bit_mask);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
      data_q  <= '0;
      aln_q   <= '0;
      merge_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            off_q   <= req_off;
            size_q  <= req_size_i;
            data_q  <= req_data_i;
            aln_q   <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            ready_q <= 1'b0;
            if (req_bad) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (req_full) begin
              state_q <= WRITE;
              merge_q <= req_data_i;
              we_q    <= 1'b1;
            end else begin
              state_q <= READ;
              re_q    <= 1'b1;
            end
          end
        end
        READ: begin
          re_q    <= 1'b0;
          cnt_q   <= CNT_W'(RD_LAT);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            merge_q <= merge_d;
            we_q    <= 1'b1;
            state_q <= WRITE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        WRITE: begin
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign mem_addr_o  = aln_q;
  assign mem_re_o    = re_q;
  assign mem_we_o    = we_q;
  assign mem_wdata_o = merge_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: three instances (32b/RD_LAT=1, 32b/RD_LAT=3, 64b/RD_LAT=1)
// checked every cycle against a transaction-timeline model.
module tb_store_merge_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic [1:0]  req_size  [3];
  logic [63:0] req_data  [3];
  logic [31:0] mem_addr  [3];
  logic        mem_re    [3];
  logic [63:0] mem_rdata [3];
  logic        mem_we    [3];
  logic        done      [3];
  logic        err       [3];
  logic [31:0] wd0;
  logic [31:0] wd1;
  logic [63:0] wd2;

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr[0]), .req_size_i(req_size[0]), .req_data_i(req_data[0][31:0]),
    .mem_addr_o(mem_addr[0]), .mem_re_o(mem_re[0]), .mem_rdata_i(mem_rdata[0][31:0]),
    .mem_we_o(mem_we[0]), .mem_wdata_o(wd0), .done_o(done[0]), .err_o(err[0]));

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr[1]), .req_size_i(req_size[1]), .req_data_i(req_data[1][31:0]),
    .mem_addr_o(mem_addr[1]), .mem_re_o(mem_re[1]), .mem_rdata_i(mem_rdata[1][31:0]),
    .mem_we_o(mem_we[1]), .mem_wdata_o(wd1), .done_o(done[1]), .err_o(err[1]));

  store_merge_unit #(.DATA_W(64), .ADDR_W(32), .RD_LAT(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_addr_i(req_addr[2]), .req_size_i(req_size[2]), .req_data_i(req_data[2]),
    .mem_addr_o(mem_addr[2]), .mem_re_o(mem_re[2]), .mem_rdata_i(mem_rdata[2]),
    .mem_we_o(mem_we[2]), .mem_wdata_o(wd2), .done_o(done[2]), .err_o(err[2]));

  function automatic int lat_of(int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int lanes_of(int i);
    return (i == 2) ? 8 : 4;
  endfunction

  function automatic logic [63:0] wdata_of(int i);
    if (i == 0) return {32'b0, wd0};
    if (i == 1) return {32'b0, wd1};
    return wd2;
  endfunction

  // Model: each instance holds one outstanding transaction (kind 0 sub-word, 1 full, 2 error)
  bit          acc   [3];
  int          c0    [3];
  int          kind  [3];
  logic [31:0] m_aln [3];
  logic [63:0] m_wd  [3];
  logic [63:0] m_rd  [3];

  function automatic int done_k(int i);
    if (kind[i] == 2) return 1;
    if (kind[i] == 1) return 2;
    return 3 + lat_of(i);
  endfunction

  function automatic bit active(int i);
    int k;
    k = cyc - c0[i];
    return acc[i] && (k >= 1) && (k <= done_k(i));
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", name, i, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int k;
      bit act, e_re, e_we, e_done;
      if (!rst_n[i]) begin
        chk("rst_ready", i, 64'(req_ready[i]), 64'd1);
        chk("rst_re", i, 64'(mem_re[i]), 64'd0);
        chk("rst_we", i, 64'(mem_we[i]), 64'd0);
        chk("rst_done", i, 64'(done[i]), 64'd0);
        chk("rst_err", i, 64'(err[i]), 64'd0);
        chk("rst_addr", i, 64'(mem_addr[i]), 64'd0);
        chk("rst_wdata", i, wdata_of(i), 64'd0);
      end else begin
        k      = cyc - c0[i];
        act    = active(i);
        e_re   = act && kind[i] == 0 && k == 1;
        e_we   = act && ((kind[i] == 0 && k == 2 + lat_of(i)) || (kind[i] == 1 && k == 1));
        e_done = act && k == done_k(i);
        chk("req_ready", i, 64'(req_ready[i]), 64'(!act));
        chk("mem_re", i, 64'(mem_re[i]), 64'(e_re));
        chk("mem_we", i, 64'(mem_we[i]), 64'(e_we));
        chk("done", i, 64'(done[i]), 64'(e_done));
        chk("err", i, 64'(err[i]), 64'(e_done && kind[i] == 2));
        if (e_re || e_we) chk("mem_addr", i, 64'(mem_addr[i]), 64'(m_aln[i]));
        if (e_we) chk("mem_wdata", i, wdata_of(i), m_wd[i]);
      end
    end
  end

  // Read data is valid only in the final WAIT cycle; garbage everywhere else.
  always @(posedge clk) begin
    #1;
    for (int j = 0; j < 3; j++) begin
      if (acc[j] && kind[j] == 0 && (cyc - c0[j]) == 1 + lat_of(j)) mem_rdata[j] = m_rd[j];
      else mem_rdata[j] = {$urandom, $urandom};
    end
  end

  task automatic issue(input int i, input logic [31:0] addr, input logic [1:0] size,
                       input logic [63:0] data, input logic [63:0] rd,
                       input int exp_kind, input logic [63:0] exp_wd);
    int guard, nb, ln, off, mk;
    logic [63:0] wd, dmask;
    guard = 0;
    @(posedge clk); #1;
    while (acc[i] && (cyc - c0[i]) <= done_k(i)) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL idle_wait inst%0d: busy after %0d cycles, expected idle", i, guard);
        return;
      end
    end
    nb    = 1 << size;
    ln    = lanes_of(i);
    off   = int'(addr) % ln;
    dmask = (ln == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    wd    = '0;
    if (nb > ln || (int'(addr) % nb) != 0) begin
      mk = 2;
    end else if (nb == ln) begin
      mk = 1;
      wd = data & dmask;
    end else begin
      mk = 0;
      wd = rd & dmask;
      for (int b = 0; b < nb; b++) wd[(off + b) * 8 +: 8] = data[b * 8 +: 8];
    end
    chk("model_kind", i, 64'(mk), 64'(exp_kind));
    if (mk != 2) chk("model_wdata", i, wd, exp_wd);
    kind[i]  = mk;
    m_wd[i]  = wd;
    m_rd[i]  = rd;
    m_aln[i] = addr & ~32'(ln - 1);
    c0[i]    = cyc;
    acc[i]   = 1'b1;
    req_valid[i] = 1'b1;
    req_addr[i]  = addr;
    req_size[i]  = size;
    req_data[i]  = data;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_addr[i]  = $urandom;
    req_size[i]  = 2'($urandom);
    req_data[i]  = {$urandom, $urandom};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i]     = 1'b0;
      req_valid[i] = 1'b0;
      req_addr[i]  = '0;
      req_size[i]  = '0;
      req_data[i]  = '0;
      mem_rdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // 32-bit, RD_LAT=1
    issue(0, 32'h1003, 2'b00, 64'hAB,        64'h11223344, 0, 64'hAB223344);
    issue(0, 32'h2002, 2'b01, 64'h0000BEEF,  64'h11223344, 0, 64'hBEEF3344);
    issue(0, 32'h3000, 2'b10, 64'hCAFEF00D,  64'h0,        1, 64'hCAFEF00D);
    issue(0, 32'h2001, 2'b01, 64'h1234,      64'h0,        2, 64'h0);
    issue(0, 32'h3002, 2'b10, 64'h1234,      64'h0,        2, 64'h0);
    issue(0, 32'h4000, 2'b11, 64'h1234,      64'h0,        2, 64'h0);
    issue(0, 32'h5001, 2'b00, 64'hFFFFFF77,  64'h0,        0, 64'h00007700);
    issue(0, 32'h6000, 2'b01, 64'h12345678,  64'hAABBCCDD, 0, 64'hAABB5678);

    // 32-bit, RD_LAT=3
    issue(1, 32'h0000, 2'b00, 64'h5A,        64'hFFFFFFFF, 0, 64'hFFFFFF5A);
    issue(1, 32'h0002, 2'b01, 64'h1234,      64'h0,        0, 64'h12340000);

    // 64-bit, RD_LAT=1
    issue(2, 32'h0104, 2'b10, 64'hDEADBEEF, 64'h0011223344556677, 0, 64'hDEADBEEF44556677);
    issue(2, 32'h0200, 2'b11, 64'h0102030405060708, 64'h0,    1, 64'h0102030405060708);
    issue(2, 32'h0010, 2'b00, 64'h42,       64'h0,               0, 64'h42);
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    acc[2]   = 1'b0;
    #1;
    chk("async_rst_ready", 2, 64'(req_ready[2]), 64'd1);
    chk("async_rst_we", 2, 64'(mem_we[2]), 64'd0);
    chk("async_rst_done", 2, 64'(done[2]), 64'd0);
    chk("async_rst_addr", 2, 64'(mem_addr[2]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    issue(2, 32'h0107, 2'b00, 64'h99,       64'h0011223344556677, 0, 64'h9911223344556677);
    issue(2, 32'h0102, 2'b10, 64'h1,        64'h0,               2, 64'h0);
    issue(2, 32'h0106, 2'b01, 64'hABCD,     64'h0011223344556677, 0, 64'hABCD223344556677);

    repeat (10) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
